proc_datapath: RTL and testbench

Processor datapath for a 16-bit single-cycle-control machine. Instantiates a 16×16 register file, an 8-function ALU, a 2:1 write-back mux and a 256×16 synchronous data memory. Every select, address and enable comes from the external controller; there is no internal sequencing. Debug outputs expose the internal buses for verification.

---
 rtl/proc_datapath.sv | 172 +++++++++++++++++
 tb/tb_proc_datapath.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_datapath.sv
// 16-bit processor datapath: register file, ALU, write-back mux and a synchronous data memory.
// All selects, addresses and enables come from an external controller; nothing is sequenced here.

module ProcRegFile (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [3:0]  raAddr_i,
    input  logic [3:0]  rbAddr_i,
    output logic [15:0] raData_o,
    output logic [15:0] rbData_o
);
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads bypass nothing: a same-cycle write is only visible after the edge.
    assign raData_o = regs_q[raAddr_i];
    assign rbData_o = regs_q[rbAddr_i];
endmodule

module ProcAlu (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [2:0]  sel_i,
    output logic [15:0] y_o
);
    typedef enum logic [2:0] {
        AluZero = 3'd0,
        AluAdd  = 3'd1,
        AluSub  = 3'd2,
        AluPass = 3'd3,
        AluXor  = 3'd4,
        AluOr   = 3'd5,
        AluAnd  = 3'd6,
        AluInc  = 3'd7
    } AluOp_e;

    AluOp_e op;

    assign op = AluOp_e'(sel_i);

    always_comb begin
        y_o = 16'h0000;
        case (op)
            AluZero: y_o = 16'h0000;
            AluAdd:  y_o = a_i + b_i;
            AluSub:  y_o = a_i - b_i;
            AluPass: y_o = a_i;
            AluXor:  y_o = a_i ^ b_i;
            AluOr:   y_o = a_i | b_i;
            AluAnd:  y_o = a_i & b_i;
            AluInc:  y_o = a_i + 16'd1;
            default: y_o = 16'h0000;
        endcase
    end
endmodule

module ProcDataMem (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [7:0]  addr_i,
    input  logic        wr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o
);
    logic [15:0] mem_q [256];
    logic [15:0] rdata_q;
    logic [15:0] rdata_d;

    // The array itself is never reset; only writes are blocked while reset is held.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && wr_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_d = wr_i ? wdata_i : mem_q[addr_i];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rdata_q <= 16'h0000;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
endmodule

module proc_datapath (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [7:0]  D_Addr_i,
    input  logic        D_wr_i,
    input  logic        RF_s_i,
    input  logic [3:0]  RF_W_addr_i,
    input  logic        RF_W_en_i,
    input  logic [3:0]  RF_Ra_addr_i,
    input  logic [3:0]  RF_Rb_addr_i,
    input  logic [2:0]  Alu_s0_i,
    output logic [15:0] Ra_data_o,
    output logic [15:0] Rb_data_o,
    output logic [15:0] Alu_out_o,
    output logic [15:0] Dmem_out_o,
    output logic [15:0] W_data_o
);
    logic [15:0] raData;
    logic [15:0] rbData;
    logic [15:0] aluOut;
    logic [15:0] dmemOut;
    logic [15:0] wData;

    ProcRegFile uRegFile (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .we_i      (RF_W_en_i),
        .waddr_i   (RF_W_addr_i),
        .wdata_i   (wData),
        .raAddr_i  (RF_Ra_addr_i),
        .rbAddr_i  (RF_Rb_addr_i),
        .raData_o  (raData),
        .rbData_o  (rbData)
    );

    ProcAlu uAlu (
        .a_i   (raData),
        .b_i   (rbData),
        .sel_i (Alu_s0_i),
        .y_o   (aluOut)
    );

    // Store data is always port A, so a store and a register write can share one edge.
    ProcDataMem uDataMem (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .addr_i    (D_Addr_i),
        .wr_i      (D_wr_i),
        .wdata_i   (raData),
        .rdata_o   (dmemOut)
    );

    assign wData = RF_s_i ? dmemOut : aluOut;

    assign Ra_data_o  = raData;
    assign Rb_data_o  = rbData;
    assign Alu_out_o  = aluOut;
    assign Dmem_out_o = dmemOut;
    assign W_data_o   = wData;
endmodule

// File: tb/tb_proc_datapath.sv
// Bench for proc_datapath: directed test-plan steps followed by random traffic,
// all checked against an array-based model of registers and memory.
`timescale 1ns/1ps

module tb_proc_datapath;
    logic        clk;
    logic        reset_n;
    logic [7:0]  dAddr;
    logic        dWr;
    logic        rfS;
    logic [3:0]  wAddr;
    logic        wEn;
    logic [3:0]  raAddr;
    logic [3:0]  rbAddr;
    logic [2:0]  aluSel;
    logic [15:0] raData;
    logic [15:0] rbData;
    logic [15:0] aluOut;
    logic [15:0] dmemOut;
    logic [15:0] wData;

    logic [15:0] mRegs [16];
    logic [15:0] mMem  [256];
    logic [15:0] mDmem;

    int nCompared;
    int nMismatched;

    proc_datapath dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .D_Addr_i     (dAddr),
        .D_wr_i       (dWr),
        .RF_s_i       (rfS),
        .RF_W_addr_i  (wAddr),
        .RF_W_en_i    (wEn),
        .RF_Ra_addr_i (raAddr),
        .RF_Rb_addr_i (rbAddr),
        .Alu_s0_i     (aluSel),
        .Ra_data_o    (raData),
        .Rb_data_o    (rbData),
        .Alu_out_o    (aluOut),
        .Dmem_out_o   (dmemOut),
        .W_data_o     (wData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: observed no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [15:0] aluRef(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
        int unsigned r;
        r = 0;
        case (sel)
            3'd1: r = int'(a) + int'(b);
            3'd2: r = 32'h10000 + int'(a) - int'(b);
            3'd3: r = int'(a);
            3'd4: r = int'(a ^ b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a & b);
            3'd7: r = int'(a) + 1;
            default: r = 0;
        endcase
        return 16'(r % 32'h10000);
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] da, input logic dw, input logic rs,
                                 input logic [3:0] wa, input logic we,
                                 input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] sel);
        dAddr  = da;
        dWr    = dw;
        rfS    = rs;
        wAddr  = wa;
        wEn    = we;
        raAddr = ra;
        rbAddr = rb;
        aluSel = sel;
        #1;
    endtask

    task automatic checkComb();
        logic [15:0] expAlu;
        expAlu = aluRef(aluSel, mRegs[raAddr], mRegs[rbAddr]);
        checkOutput("Ra_data", raData, mRegs[raAddr]);
        checkOutput("Rb_data", rbData, mRegs[rbAddr]);
        checkOutput("Alu_out", aluOut, expAlu);
        checkOutput("Dmem_out", dmemOut, mDmem);
        checkOutput("W_data", wData, rfS ? mDmem : expAlu);
    endtask

    // One clock edge; the model applies the architectural rules using pre-edge values.
    task automatic tick();
        logic [15:0] a;
        logic [15:0] wd;
        a  = mRegs[raAddr];
        wd = rfS ? mDmem : aluRef(aluSel, mRegs[raAddr], mRegs[rbAddr]);
        @(posedge clk);
        if (reset_n) begin
            if (dWr) begin
                mMem[dAddr] = a;
                mDmem = a;
            end else begin
                mDmem = mMem[dAddr];
            end
            if (wEn) mRegs[wAddr] = wd;
        end
        @(negedge clk);
    endtask

    task automatic assertReset();
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
        mDmem = 16'h0000;
        #1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
        for (int i = 0; i < 256; i++) mMem[i] = 16'h0000;
        mDmem   = 16'h0000;
        reset_n = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
        checkComb();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Increment chain: R1 = R0 + 1, R2 = R1 + 1, R3 = R2 + R2
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 4'd0, 3'd7);
        checkComb();
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd2, 1'b1, 4'd1, 4'd0, 3'd7);
        checkOutput("inc R1", raData, 16'd1);
        checkComb();
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd2, 4'd2, 3'd1);
        checkOutput("inc R2", raData, 16'd2);
        checkOutput("add R2+R2", aluOut, 16'd4);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd2, 3'd2);
        checkOutput("R3", raData, 16'd4);

        // ALU sweep with A = R3 = 4, B = R2 = 2
        checkOutput("sub 4-2", aluOut, 16'd2);
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd2, 3'd4);
        checkOutput("xor 4^2", aluOut, 16'd6);
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd2, 3'd5);
        checkOutput("or 4|2", aluOut, 16'd6);
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd2, 3'd6);
        checkOutput("and 4&2", aluOut, 16'd0);
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd0, 4'd1, 3'd2);
        checkOutput("sub 0-1", aluOut, 16'hFFFF);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd6, 4'd0, 3'd7);
        checkOutput("inc FFFF", aluOut, 16'h0000);
        checkComb();

        // Store/load round trip through address 0xA5
        applyStimulus(8'hA5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, 3'd0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 4'd0, 3'd0);
        tick();
        applyStimulus(8'hA5, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd0, 3'd0);
        checkOutput("R3 cleared", raData, 16'd0);
        tick();
        applyStimulus(8'hA5, 1'b0, 1'b1, 4'd5, 1'b1, 4'd0, 4'd0, 3'd0);
        checkOutput("load Dmem", dmemOut, 16'd4);
        checkOutput("load W_data", wData, 16'd4);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 4'd2, 3'd0);
        checkOutput("load R5", raData, 16'd4);

        // Write-through of R2 to 0x00, then untouched 0xFF
        applyStimulus(8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 4'd2, 4'd0, 3'd0);
        tick();
        applyStimulus(8'hFF, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
        checkOutput("write-through", dmemOut, 16'd2);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
        checkOutput("addr FF", dmemOut, 16'd0);
        tick();

        // Mux switching and write enable gating (Dmem = 2, Alu = R3 + 1 = 1)
        applyStimulus(8'h00, 1'b0, 1'b1, 4'd4, 1'b0, 4'd3, 4'd0, 3'd7);
        checkOutput("mux dmem", wData, 16'd2);
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd4, 1'b0, 4'd3, 4'd0, 3'd7);
        checkOutput("mux alu", wData, 16'd1);
        applyStimulus(8'h00, 1'b0, 1'b1, 4'd4, 1'b0, 4'd3, 4'd0, 3'd7);
        tick();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'(i), 4'(15 - i), 3'd0);
            checkComb();
        end

        // Random traffic, including simultaneous RF and memory writes
        for (int n = 0; n < 400; n++) begin
            applyStimulus(8'($urandom_range(0, 15) < 8 ? $urandom_range(0, 7) : $urandom_range(0, 255)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom), 1'($urandom),
                          4'($urandom), 4'($urandom), 3'($urandom));
            checkComb();
            tick();
        end

        // Reset pulse with populated registers: everything reads zero, writes blocked
        assertReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'hA5, 1'b1, 1'b0, 4'(i), 1'b1, 4'(i), 4'(15 - i), 3'd7);
            checkOutput("rst Ra", raData, 16'd0);
            checkOutput("rst Rb", rbData, 16'd0);
            checkOutput("rst Dmem", dmemOut, 16'd0);
            checkOutput("rst Alu inc", aluOut, 16'd1);
        end
        tick();
        applyStimulus(8'hA5, 1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 4'd0, 3'd0);
        checkComb();
        reset_n = 1'b1;
        #1;
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 4'd0, 3'd0);
        checkComb();
        tick();

        // Reset mid-load: Dmem drops to 0, later write-back writes 0
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0);
        checkComb();
        assertReset();
        checkOutput("midload Dmem", dmemOut, 16'd0);
        reset_n = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b1, 4'd7, 1'b1, 4'd0, 4'd0, 3'd7);
        checkComb();
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, 3'd0);
        checkOutput("midload R7", raData, 16'd0);
        checkComb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
